// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel key synchronizer, debouncer and long-press reset request
// Raw active-low keys become clean pressed levels, press/release pulses and a hold-to-reset request.
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int HOLD_KEY        = 0
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [NUM_KEYS-1:0] iKEY_N,
  output logic [NUM_KEYS-1:0] oKEY,
  output logic [NUM_KEYS-1:0] oPRESS,
  output logic [NUM_KEYS-1:0] oRELEASE,
  output logic                oRSTN_REQ
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);

  logic [NUM_KEYS-1:0] syncMeta;
  logic [NUM_KEYS-1:0] syncOut;
  logic [NUM_KEYS-1:0] keySync;
  logic [CW-1:0]       dbCnt [NUM_KEYS];
  logic [HW-1:0]       holdCnt;

  // Sync flops hold the raw active-low key, so reset to 1 means released.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      syncMeta <= '1;
      syncOut  <= '1;
    end else begin
      syncMeta <= iKEY_N;
      syncOut  <= syncMeta;
    end
  end

  assign keySync = ~syncOut;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oKEY     <= '0;
      oPRESS   <= '0;
      oRELEASE <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      oPRESS   <= '0;
      oRELEASE <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (keySync[i] == oKEY[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_LAST) begin
          // The pulse is registered alongside the level so both change on the same edge.
          oKEY[i]     <= keySync[i];
          oPRESS[i]   <= keySync[i];
          oRELEASE[i] <= ~keySync[i];
          dbCnt[i]    <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  // Hold counter saturates one past the threshold so the request stays asserted.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      holdCnt   <= '0;
      oRSTN_REQ <= 1'b1;
    end else if (!oKEY[HOLD_KEY]) begin
      holdCnt   <= '0;
      oRSTN_REQ <= 1'b1;
    end else if (holdCnt == HOLD_LAST) begin
      holdCnt   <= HOLD_SAT;
      oRSTN_REQ <= 1'b0;
    end else if (holdCnt < HOLD_LAST) begin
      holdCnt <= holdCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with a history-window reference model
// Model pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int HK = 0;

  typedef logic [3*NK:0] exp_t;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [NK-1:0] iKEY_N;
  logic [NK-1:0] oKEY;
  logic [NK-1:0] oPRESS;
  logic [NK-1:0] oRELEASE;
  logic          oRSTN_REQ;

  int tests = 0;
  int fails = 0;

  always #5 iCLK = ~iCLK;

  key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .HOLD_KEY(HK)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY_N(iKEY_N),
    .oKEY(oKEY), .oPRESS(oPRESS), .oRELEASE(oRELEASE), .oRSTN_REQ(oRSTN_REQ)
  );

  exp_t          sb[$];
  logic [NK-1:0] rawQ[$];
  logic [NK-1:0] sQ[$];
  logic [NK-1:0] mLevel = '0;
  longint        edgeNo = 0;
  longint        riseEdge = 0;

  // A level flips once the last DB synced samples all disagree with it.
  always @(posedge iCLK) begin : model
    logic [NK-1:0] s, pr, rl, nl;
    logic          rq;
    bit            flip;
    edgeNo++;
    if (iRST) begin
      rawQ.delete();
      sQ.delete();
      mLevel = '0;
      sb.push_back({{NK{1'b0}}, {NK{1'b0}}, {NK{1'b0}}, 1'b1});
    end else begin
      s = (rawQ.size() >= 2) ? rawQ[rawQ.size()-2] : '0;
      rawQ.push_back(~iKEY_N);
      if (rawQ.size() > 2) void'(rawQ.pop_front());
      sQ.push_back(s);
      if (sQ.size() > DB) void'(sQ.pop_front());
      pr = '0;
      rl = '0;
      nl = mLevel;
      for (int c = 0; c < NK; c++) begin
        flip = (sQ.size() == DB);
        foreach (sQ[j]) if (sQ[j][c] == mLevel[c]) flip = 0;
        if (flip) begin
          nl[c] = ~mLevel[c];
          pr[c] = nl[c];
          rl[c] = mLevel[c];
        end
      end
      rq = !(mLevel[HK] && (edgeNo - riseEdge >= HC));
      if (pr[HK]) riseEdge = edgeNo;
      mLevel = nl;
      sb.push_back({nl, pr, rl, rq});
    end
  end

  bit     started = 0;
  int     cyc = 0;
  int     riseAt = 0;
  int     pulses1 = 0;
  int     press1 = 0;
  logic   prevKey0 = 1'b0;
  logic   prevRstn = 1'b1;
  exp_t   e;
  exp_t   got;

  always @(negedge iCLK) begin
    cyc++;
    if (sb.size() == 0) begin
      if (started) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: no expected entry at cycle %0d", cyc);
      end
    end else begin
      started = 1;
      e   = sb.pop_front();
      got = {oKEY, oPRESS, oRELEASE, oRSTN_REQ};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got key/press/rel/rstn=%b required %b", cyc, got, e);
      end
      if (oPRESS[1] === 1'b1) press1++;
      if (oPRESS[1] === 1'b1 || oRELEASE[1] === 1'b1) pulses1++;
      if (oKEY[0] === 1'b1 && prevKey0 !== 1'b1) riseAt = cyc;
      if (oRSTN_REQ === 1'b0 && prevRstn === 1'b1) begin
        tests++;
        if (cyc - riseAt != HC) begin
          fails++;
          $display("FAIL hold_latency: got %0d edges required %0d", cyc - riseAt, HC);
        end
      end
      prevKey0 = oKEY[0];
      prevRstn = oRSTN_REQ;
    end
  end

  task automatic hold(input logic [NK-1:0] v, input int n);
    iKEY_N = v;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_reset(input logic [NK-1:0] v);
    iKEY_N = v;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
  endtask

  initial begin
    iRST   = 1'b1;
    iKEY_N = '1;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;

    hold(2'b11, 5);
    hold(2'b01, 20);
    hold(2'b11, 10);

    pulses1 = 0;
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 2'b01 : 2'b11, 3);
    hold(2'b11, 10);
    tests++;
    if (pulses1 != 0) begin
      fails++;
      $display("FAIL bounce_reject: got %0d pulses required 0", pulses1);
    end

    press1 = 0;
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 2'b01 : 2'b11, 2);
    hold(2'b01, 12);
    tests++;
    if (press1 != 1) begin
      fails++;
      $display("FAIL bounce_settle: got %0d presses required 1", press1);
    end
    hold(2'b11, 10);

    hold(2'b10, 40);
    hold(2'b11, 20);

    hold(2'b10, 12);
    hold(2'b11, 20);

    hold(2'b10, 17);
    pulse_reset(2'b10);
    hold(2'b10, 30);
    hold(2'b11, 20);

    repeat (150) begin
      if ($urandom_range(0, 29) == 0) pulse_reset(NK'($urandom));
      if ($urandom_range(0, 3) == 0) hold(NK'($urandom), $urandom_range(12, 30));
      else hold(NK'($urandom), $urandom_range(1, 12));
    end
    hold('1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
